// File: rtl/mux2_arb_pkg.sv
// rtl/mux2_arb_pkg.sv - shared state encoding and counter sizing for the 2-port arbiter
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    function automatic int cnt_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/mux2_w.sv
// rtl/mux2_w.sv - parameterised 2:1 word selector
module mux2_w #(
    parameter int DATA_W = 1
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    output logic [DATA_W-1:0] y
);

    assign y = sel ? i1 : i0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin, burst-bounded arbiter driving a registered 2:1 mux
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    localparam int             CW       = cnt_w(MAX_BURST);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] mux_y;
    logic              beat;
    logic              own_req, oth_req;
    state_e            oth_st;

    assign gnt0      = (state_q == GNT0) && req0;
    assign gnt1      = (state_q == GNT1) && req1;
    assign beat      = gnt0 || gnt1;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // sel_q tracks the granted port, so it already steers the mux during a beat
    mux2_w #(.DATA_W(DATA_W)) u_mux (
        .sel (sel_q),
        .i0  (data0),
        .i1  (data1),
        .y   (mux_y)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_req = (state_q == GNT1) ? req1 : req0;
        oth_req = (state_q == GNT1) ? req0 : req1;
        oth_st  = (state_q == GNT1) ? GNT0 : GNT1;
        case (state_q)
            IDLE: begin
                if (req0 && req1)
                    state_d = last_q ? GNT0 : GNT1;
                else if (req0)
                    state_d = GNT0;
                else if (req1)
                    state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (!own_req)
                    state_d = oth_req ? oth_st : IDLE;
                else if (cnt_q == CNT_LAST) begin
                    if (oth_req)
                        state_d = oth_st;
                    else
                        cnt_d = '0;
                end else
                    cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q)
            cnt_d = '0;

        last_d = last_q;
        sel_d  = sel_q;
        if (state_d == GNT0) begin
            last_d = 1'b0;
            sel_d  = 1'b0;
        end else if (state_d == GNT1) begin
            last_d = 1'b1;
            sel_d  = 1'b1;
        end

        out_valid_d = beat;
        out_data_d  = beat ? mux_y : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - scoreboard bench for mux2_rr_arbiter (burst 4 and burst 1 instances)
module tb_mux2_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       gnt0_a, gnt1_a, sel_a, out_valid_a;
    logic [7:0] out_data_a;
    logic       gnt0_b, gnt1_b, sel_b, out_valid_b;
    logic [7:0] out_data_b;

    int checks = 0;
    int errors = 0;

    mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a),
        .out_valid(out_valid_a), .out_data(out_data_a)
    );

    mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b),
        .out_valid(out_valid_b), .out_data(out_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: owner -1 = nobody holds the grant, else the port index.
    typedef struct {
        int owner;
        int cnt;
        int last;
        int sel;
    } ms_t;

    localparam ms_t MS_RESET = '{owner: -1, cnt: 0, last: 1, sel: 0};

    function automatic ms_t mstep(input ms_t s, input bit r0, input bit r1, input int mb);
        ms_t n;
        bit  r[2];
        int  nxt;
        int  p;
        n    = s;
        r[0] = r0;
        r[1] = r1;
        if (s.owner < 0) begin
            if (r0 && r1)  nxt = (s.last == 1) ? 0 : 1;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            else           nxt = -1;
        end else begin
            p = s.owner;
            if (!r[p])                nxt = r[1-p] ? 1 - p : -1;
            else if (s.cnt + 1 == mb) nxt = r[1-p] ? 1 - p : p;
            else                      nxt = p;
        end
        if (nxt != s.owner)  n.cnt = 0;
        else if (nxt >= 0)   n.cnt = (s.cnt + 1 == mb) ? 0 : s.cnt + 1;
        n.owner = nxt;
        if (nxt >= 0) begin
            n.last = nxt;
            n.sel  = nxt;
        end
        return n;
    endfunction

    ms_t        ma = MS_RESET;
    ms_t        mb = MS_RESET;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         ea0, ea1, eb0, eb1;
    logic [7:0] xa, xb;

    always @(negedge clk) begin
        if (rst_n) begin
            ea0 = (ma.owner == 0) && req0;
            ea1 = (ma.owner == 1) && req1;
            chk("a_gnt0", gnt0_a, ea0);
            chk("a_gnt1", gnt1_a, ea1);
            chk("a_sel", sel_a, ma.sel);
            if (ea0) qa.push_back(data0);
            else if (ea1) qa.push_back(data1);
            ma = mstep(ma, req0, req1, 4);

            eb0 = (mb.owner == 0) && req0;
            eb1 = (mb.owner == 1) && req1;
            chk("b_gnt0", gnt0_b, eb0);
            chk("b_gnt1", gnt1_b, eb1);
            chk("b_sel", sel_b, mb.sel);
            if (eb0) qb.push_back(data0);
            else if (eb1) qb.push_back(data1);
            mb = mstep(mb, req0, req1, 1);
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (out_valid_a) begin
                if (qa.size() == 0) chk("a_out_valid_unexpected", out_valid_a, 1'b0);
                else begin
                    xa = qa.pop_front();
                    chk("a_out_data", out_data_a, xa);
                end
            end else if (qa.size() > 1) begin
                xa = qa.pop_front();
                chk("a_out_valid_missing", out_valid_a, 1'b1);
            end
            if (out_valid_b) begin
                if (qb.size() == 0) chk("b_out_valid_unexpected", out_valid_b, 1'b0);
                else begin
                    xb = qb.pop_front();
                    chk("b_out_data", out_data_b, xb);
                end
            end else if (qb.size() > 1) begin
                xb = qb.pop_front();
                chk("b_out_valid_missing", out_valid_b, 1'b1);
            end
        end
    end

    // Requester: hold req/data until the burst-4 instance grants, then present the wanted state.
    task automatic cyc(input bit w0, input bit w1);
        bit g0, g1;
        @(negedge clk);
        g0 = gnt0_a;
        g1 = gnt1_a;
        @(posedge clk);
        #1;
        if (!req0 || g0) begin req0 = w0; data0 = 8'($urandom); end
        if (!req1 || g1) begin req1 = w1; data1 = 8'($urandom); end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        qa.delete();
        qb.delete();
        ma = MS_RESET;
        mb = MS_RESET;
        #1;
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_out_data", out_data_a, 8'h00);
        chk("rst_sel", sel_a, 1'b0);
        chk("rst_gnt1", gnt1_a, 1'b0);
        chk("rst_gnt0", gnt0_a, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;

        // single requester latency
        do_reset();
        req0  = 1'b1;
        data0 = 8'hA5;
        @(negedge clk);
        chk("t1_idle_gnt0", gnt0_a, 1'b0);
        @(negedge clk);
        chk("t1_gnt0", gnt0_a, 1'b1);
        chk("t1_sel", sel_a, 1'b0);
        @(negedge clk);
        chk("t1_out_valid", out_valid_a, 1'b1);
        chk("t1_out_data", out_data_a, 8'hA5);
        repeat (3) cyc(0, 0);

        // both continuous: bursts of 4 (instance a), alternation (instance b)
        do_reset();
        repeat (24) cyc(1, 1);

        // port 1 alone
        repeat (12) cyc(0, 1);

        // drop port 0 mid-grant, then drop port 1
        repeat (3) cyc(1, 0);
        repeat (4) cyc(0, 1);
        repeat (4) cyc(0, 0);
        @(negedge clk);
        chk("t4_idle_sel", sel_a, 1'b1);
        chk("t4_idle_valid", out_valid_a, 1'b0);

        // reset in the middle of a port-1 burst
        do_reset();
        repeat (3) cyc(0, 1);
        chk("t5_pre_gnt1", gnt1_a, 1'b1);
        do_reset();
        cyc(1, 1);
        cyc(1, 1);
        @(negedge clk);
        chk("t5_port0_first", gnt0_a, 1'b1);
        chk("t5_port1_waits", gnt1_a, 1'b0);
        repeat (8) cyc(1, 1);

        // random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        repeat (4) cyc(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
